// File: rtl/if_id_stall_executor.sv
// if_id_stall_executor: applies the hazard unit's stall/flush controls
// to PC, IF/ID and ID/EX, counts stalls and flushes, flags bad triples.
//
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   PCWrite, IF_ID_Write      hold controls (0 = hold)
//   ControlSignalSelector     1 = insert a bubble into ID/EX
//   BranchTaken, BranchTarget flush and redirect
//   Instr_in, Ctrl_in         fetched instruction and ID control bundle
//   PC, IF_ID_*, ID_EX_*      registered pipeline state
//   StallCount, FlushCount    saturating event counters
//   ProtocolError             sticky hazard-protocol violation flag
module if_id_stall_executor #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          CTRL_W    = 9,
  parameter int          MAX_STALL = 2,
  parameter int          CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              PCWrite,
  input  logic              IF_ID_Write,
  input  logic              ControlSignalSelector,
  input  logic              BranchTaken,
  input  logic [31:0]       BranchTarget,
  input  logic [31:0]       Instr_in,
  input  logic [CTRL_W-1:0] Ctrl_in,
  output logic [31:0]       PC,
  output logic [31:0]       IF_ID_Instr,
  output logic [31:0]       IF_ID_PCPlus4,
  output logic              IF_ID_Valid,
  output logic [CTRL_W-1:0] ID_EX_Ctrl,
  output logic              ID_EX_Valid,
  output logic [CNT_W-1:0]  StallCount,
  output logic [CNT_W-1:0]  FlushCount,
  output logic              ProtocolError
);

  // Wide enough to hold MAX_STALL+1, the saturation point.
  localparam int SC_W = $clog2(MAX_STALL + 2);
  localparam logic [SC_W-1:0] SC_MAX = SC_W'(MAX_STALL + 1);
  localparam logic [SC_W-1:0] SC_LIM = SC_W'(MAX_STALL);

  logic [31:0]       pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;
  logic [31:0]       pc4_q, pc4_d;
  logic              ifv_q, ifv_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              exv_q, exv_d;
  logic [CNT_W-1:0]  stc_q, stc_d;
  logic [CNT_W-1:0]  flc_q, flc_d;
  logic [SC_W-1:0]   sc_q, sc_d;
  logic              err_q, err_d;

  logic        stall;
  logic        viol;
  logic [31:0] pc_plus4;

  // A taken branch wins over a simultaneous stall.
  assign stall    = ControlSignalSelector & ~BranchTaken;
  assign pc_plus4 = pc_q + 32'd4;

  // Legal triples are only (1,1,0) and (0,0,1).
  assign viol = (PCWrite != IF_ID_Write)
              | (ControlSignalSelector == PCWrite)
              | (stall && (sc_q >= SC_LIM));

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    ifv_d   = ifv_q;
    ctrl_d  = Ctrl_in;
    exv_d   = ifv_q;
    stc_d   = stc_q;
    flc_d   = flc_q;
    sc_d    = '0;
    err_d   = err_q | viol;

    if (BranchTaken)  pc_d = BranchTarget;
    else if (PCWrite) pc_d = pc_plus4;

    if (BranchTaken) begin
      instr_d = '0;
      pc4_d   = '0;
      ifv_d   = 1'b0;
    end else if (IF_ID_Write) begin
      instr_d = Instr_in;
      pc4_d   = pc_plus4;
      ifv_d   = 1'b1;
    end

    if (BranchTaken || ControlSignalSelector) begin
      ctrl_d = '0;
      exv_d  = 1'b0;
    end

    if (stall && !(&stc_q))      stc_d = stc_q + 1'b1;
    if (BranchTaken && !(&flc_q)) flc_d = flc_q + 1'b1;

    if (stall) sc_d = (sc_q == SC_MAX) ? sc_q : sc_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      instr_q <= '0;
      pc4_q   <= '0;
      ifv_q   <= 1'b0;
      ctrl_q  <= '0;
      exv_q   <= 1'b0;
      stc_q   <= '0;
      flc_q   <= '0;
      sc_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      ifv_q   <= ifv_d;
      ctrl_q  <= ctrl_d;
      exv_q   <= exv_d;
      stc_q   <= stc_d;
      flc_q   <= flc_d;
      sc_q    <= sc_d;
      err_q   <= err_d;
    end
  end

  assign PC            = pc_q;
  assign IF_ID_Instr   = instr_q;
  assign IF_ID_PCPlus4 = pc4_q;
  assign IF_ID_Valid   = ifv_q;
  assign ID_EX_Ctrl    = ctrl_q;
  assign ID_EX_Valid   = exv_q;
  assign StallCount    = stc_q;
  assign FlushCount    = flc_q;
  assign ProtocolError = err_q;

endmodule

// File: tb/tb_if_id_stall_executor.sv
// Directed bench for if_id_stall_executor.
// Counter width is reduced to 8 so saturation is reachable quickly.
module tb_if_id_stall_executor;

  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          PCWrite, IF_ID_Write, ControlSignalSelector;
  logic          BranchTaken;
  logic [31:0]   BranchTarget, Instr_in;
  logic [8:0]    Ctrl_in;
  logic [31:0]   PC, IF_ID_Instr, IF_ID_PCPlus4;
  logic          IF_ID_Valid, ID_EX_Valid, ProtocolError;
  logic [8:0]    ID_EX_Ctrl;
  logic [CW-1:0] StallCount, FlushCount;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  if_id_stall_executor #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write),
    .ControlSignalSelector(ControlSignalSelector),
    .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
    .Instr_in(Instr_in), .Ctrl_in(Ctrl_in),
    .PC(PC), .IF_ID_Instr(IF_ID_Instr),
    .IF_ID_PCPlus4(IF_ID_PCPlus4), .IF_ID_Valid(IF_ID_Valid),
    .ID_EX_Ctrl(ID_EX_Ctrl), .ID_EX_Valid(ID_EX_Valid),
    .StallCount(StallCount), .FlushCount(FlushCount),
    .ProtocolError(ProtocolError)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go();
    PCWrite = 1; IF_ID_Write = 1; ControlSignalSelector = 0;
    BranchTaken = 0;
  endtask

  task automatic stl();
    PCWrite = 0; IF_ID_Write = 0; ControlSignalSelector = 1;
    BranchTaken = 0;
  endtask

  task automatic do_reset();
    rst = 1; step(); rst = 0; go();
  endtask

  task automatic test_reset();
    rst = 1;
    for (int i = 0; i < 2; i++) begin
      PCWrite = 1'($urandom); IF_ID_Write = 1'($urandom);
      ControlSignalSelector = 1'($urandom);
      BranchTaken = 1'($urandom); BranchTarget = $urandom;
      Instr_in = $urandom; Ctrl_in = 9'($urandom);
      step();
    end
    total++; if (PC !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h exp=0", PC); end
    total++; if (IF_ID_Valid !== 1'b0 || ID_EX_Valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b%b exp=00", IF_ID_Valid, ID_EX_Valid); end
    total++; if (IF_ID_Instr !== 32'h0 || ID_EX_Ctrl !== 9'h0) begin bad++; $display("FAIL rst_regs got=%h/%h exp=0/0", IF_ID_Instr, ID_EX_Ctrl); end
    total++; if (StallCount !== '0 || FlushCount !== '0 || ProtocolError !== 1'b0) begin bad++; $display("FAIL rst_cnt got=%h/%h/%b exp=0/0/0", StallCount, FlushCount, ProtocolError); end
    rst = 0;
  endtask

  task automatic test_fetch();
    go(); Instr_in = 32'h8C08_0000; Ctrl_in = 9'h1A5;
    step();
    total++; if (PC !== 32'h4) begin bad++; $display("FAIL fetch_pc1 got=%h exp=4", PC); end
    total++; if (IF_ID_Instr !== 32'h8C08_0000 || IF_ID_PCPlus4 !== 32'h4 || IF_ID_Valid !== 1'b1) begin bad++; $display("FAIL fetch_ifid got=%h/%h/%b exp=8c080000/4/1", IF_ID_Instr, IF_ID_PCPlus4, IF_ID_Valid); end
    total++; if (ID_EX_Valid !== 1'b0) begin bad++; $display("FAIL fetch_exv0 got=%b exp=0", ID_EX_Valid); end
    Instr_in = 32'h2000_0001;
    step();
    total++; if (PC !== 32'h8) begin bad++; $display("FAIL fetch_pc2 got=%h exp=8", PC); end
    total++; if (ID_EX_Ctrl !== 9'h1A5 || ID_EX_Valid !== 1'b1) begin bad++; $display("FAIL fetch_idex got=%h/%b exp=1a5/1", ID_EX_Ctrl, ID_EX_Valid); end
    total++; if (IF_ID_Instr !== 32'h2000_0001 || IF_ID_PCPlus4 !== 32'h8) begin bad++; $display("FAIL fetch_ifid2 got=%h/%h exp=20000001/8", IF_ID_Instr, IF_ID_PCPlus4); end
  endtask

  task automatic test_load_use();
    stl(); Instr_in = 32'hDEAD_BEEF; Ctrl_in = 9'h0F3;
    step();
    total++; if (PC !== 32'h8) begin bad++; $display("FAIL lu_pc got=%h exp=8", PC); end
    total++; if (IF_ID_Instr !== 32'h2000_0001 || IF_ID_PCPlus4 !== 32'h8 || IF_ID_Valid !== 1'b1) begin bad++; $display("FAIL lu_ifid_hold got=%h/%h/%b exp=20000001/8/1", IF_ID_Instr, IF_ID_PCPlus4, IF_ID_Valid); end
    total++; if (ID_EX_Ctrl !== 9'h0 || ID_EX_Valid !== 1'b0) begin bad++; $display("FAIL lu_bubble got=%h/%b exp=0/0", ID_EX_Ctrl, ID_EX_Valid); end
    total++; if (StallCount !== 8'd1 || ProtocolError !== 1'b0) begin bad++; $display("FAIL lu_cnt got=%0d/%b exp=1/0", StallCount, ProtocolError); end
    go(); Instr_in = 32'h0000_0013;
    step();
    total++; if (PC !== 32'hC || IF_ID_Instr !== 32'h13 || IF_ID_PCPlus4 !== 32'hC) begin bad++; $display("FAIL lu_resume got=%h/%h/%h exp=c/13/c", PC, IF_ID_Instr, IF_ID_PCPlus4); end
    total++; if (ID_EX_Ctrl !== 9'h0F3 || ID_EX_Valid !== 1'b1) begin bad++; $display("FAIL lu_idex got=%h/%b exp=0f3/1", ID_EX_Ctrl, ID_EX_Valid); end
  endtask

  task automatic test_branch_stall();
    stl(); BranchTaken = 1; BranchTarget = 32'h40;
    step();
    total++; if (PC !== 32'h40) begin bad++; $display("FAIL br_pc got=%h exp=40", PC); end
    total++; if (IF_ID_Valid !== 1'b0 || IF_ID_Instr !== 32'h0 || ID_EX_Valid !== 1'b0) begin bad++; $display("FAIL br_flush got=%b/%h/%b exp=0/0/0", IF_ID_Valid, IF_ID_Instr, ID_EX_Valid); end
    total++; if (FlushCount !== 8'd1 || StallCount !== 8'd1 || ProtocolError !== 1'b0) begin bad++; $display("FAIL br_cnt got=%0d/%0d/%b exp=1/1/0", FlushCount, StallCount, ProtocolError); end
    go(); Instr_in = 32'h1111_2222;
    step();
    total++; if (PC !== 32'h44 || IF_ID_Valid !== 1'b1 || ID_EX_Valid !== 1'b0) begin bad++; $display("FAIL br_after got=%h/%b/%b exp=44/1/0", PC, IF_ID_Valid, ID_EX_Valid); end
  endtask

  task automatic test_proto_mismatch();
    PCWrite = 1; IF_ID_Write = 0; ControlSignalSelector = 0;
    step();
    total++; if (ProtocolError !== 1'b1) begin bad++; $display("FAIL pe_set got=%b exp=1", ProtocolError); end
    total++; if (PC !== 32'h48 || IF_ID_PCPlus4 !== 32'h44) begin bad++; $display("FAIL pe_datapath got=%h/%h exp=48/44", PC, IF_ID_PCPlus4); end
    go(); step(); step();
    total++; if (ProtocolError !== 1'b1) begin bad++; $display("FAIL pe_sticky got=%b exp=1", ProtocolError); end
    do_reset();
    total++; if (ProtocolError !== 1'b0) begin bad++; $display("FAIL pe_clear got=%b exp=0", ProtocolError); end
  endtask

  task automatic test_runaway();
    stl();
    step(); step();
    total++; if (ProtocolError !== 1'b0) begin bad++; $display("FAIL run_two got=%b exp=0", ProtocolError); end
    step();
    total++; if (ProtocolError !== 1'b1 || StallCount !== 8'd3) begin bad++; $display("FAIL run_three got=%b/%0d exp=1/3", ProtocolError, StallCount); end
    total++; if (PC !== 32'h0) begin bad++; $display("FAIL run_pc got=%h exp=0", PC); end
    do_reset();
  endtask

  task automatic test_wrap_sat();
    go(); BranchTaken = 1; BranchTarget = 32'hFFFF_FFFC;
    step();
    total++; if (PC !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_br got=%h exp=fffffffc", PC); end
    go(); Instr_in = 32'hABCD_0000;
    step();
    total++; if (PC !== 32'h0 || IF_ID_PCPlus4 !== 32'h0 || IF_ID_Valid !== 1'b1) begin bad++; $display("FAIL wrap_pc got=%h/%h/%b exp=0/0/1", PC, IF_ID_PCPlus4, IF_ID_Valid); end
    do_reset();
    // 127 x (stall, stall, go) then one stall = 255 legal stalls.
    for (int i = 0; i < 127; i++) begin
      stl(); step(); step(); go(); step();
    end
    stl(); step();
    total++; if (StallCount !== 8'hFF || ProtocolError !== 1'b0) begin bad++; $display("FAIL sat_fill got=%h/%b exp=ff/0", StallCount, ProtocolError); end
    step();
    total++; if (StallCount !== 8'hFF || ProtocolError !== 1'b0) begin bad++; $display("FAIL sat_hold got=%h/%b exp=ff/0", StallCount, ProtocolError); end
    go(); step();
  endtask

  initial begin
    rst = 1; go(); BranchTarget = 0; Instr_in = 0; Ctrl_in = 0;
    test_reset();
    test_fetch();
    test_load_use();
    test_branch_stall();
    test_proto_mismatch();
    test_runaway();
    test_wrap_sat();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_id_stall_executor.md
Name: if_id_stall_executor

Overview:
- Consumer end of the load-use hazard protocol.
- Takes the stall triple (PCWrite, IF_ID_Write, ControlSignalSelector) from hazard detection and applies it:
  - holds the PC and the IF/ID register;
  - injects a control bubble into ID/EX;
  - flushes on a taken branch.
- Also counts stalls and flushes, and flags protocol violations from the hazard producer (mismatched triple or a runaway stall).

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- CTRL_W, 9, width of the ID-stage control bundle passed to ID/EX
- MAX_STALL, 2, maximum legal consecutive stall cycles before an error is flagged
- CNT_W, 16, width of the stall and flush counters

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- PCWrite  in  1  1 = PC may advance, 0 = hold PC
- IF_ID_Write  in  1  1 = IF/ID may load, 0 = hold IF/ID
- ControlSignalSelector  in  1  1 = zero the control bundle into ID/EX (bubble)
- BranchTaken  in  1  branch resolved taken this cycle; flush request
- BranchTarget  in  32  redirect address, valid when BranchTaken=1
- Instr_in  in  32  instruction memory read data for the current PC
- Ctrl_in  in  CTRL_W  control bundle from the main control unit for the IF/ID instruction
- PC  out  32  current fetch address
- IF_ID_Instr  out  32  registered instruction
- IF_ID_PCPlus4  out  32  registered PC+4
- IF_ID_Valid  out  1  IF/ID holds a real instruction
- ID_EX_Ctrl  out  CTRL_W  registered control bundle
- ID_EX_Valid  out  1  ID/EX holds a real instruction
- StallCount  out  CNT_W  bubbles inserted, saturating
- FlushCount  out  CNT_W  branch flushes, saturating
- ProtocolError  out  1  sticky violation flag

Behaviour:
- Reset values, taking effect on the edge where rst=1:
  - PC=RESET_PC
  - IF_ID_Instr=0 (nop), IF_ID_PCPlus4=0, IF_ID_Valid=0
  - ID_EX_Ctrl=0, ID_EX_Valid=0
  - StallCount=0, FlushCount=0, ProtocolError=0
  - internal consecutive-stall counter=0
- rst overrides every other input.
- PC update, priority order:
  - rst
  - BranchTaken → PC=BranchTarget
  - PCWrite=1 → PC=PC+4 (32-bit wrap, FFFF_FFFC→0000_0000)
  - else hold
- IF/ID update, priority order:
  - rst
  - BranchTaken → Instr=0, PCPlus4=0, Valid=0
  - IF_ID_Write=1 → load Instr_in, PC+4, Valid=1
  - else hold all three
- ID/EX update, priority order:
  - rst
  - BranchTaken → Ctrl=0, Valid=0
  - ControlSignalSelector=1 → Ctrl=0, Valid=0
  - else Ctrl=Ctrl_in, Valid=IF_ID_Valid
- Latency:
  - Instr_in appears on IF_ID_Instr one cycle after the PC that fetched it.
  - Ctrl_in appears on ID_EX_Ctrl one cycle later.
- A taken branch always wins over a simultaneous stall: no hold, no StallCount increment.
- StallCount increments by 1 when ControlSignalSelector=1 and BranchTaken=0; saturates at all-ones.
- FlushCount increments by 1 when BranchTaken=1; saturates.
- Consecutive-stall counter:
  - increments while ControlSignalSelector=1 and BranchTaken=0;
  - clears otherwise;
  - saturates at MAX_STALL+1.
- ProtocolError is set on the next edge when any of these hold, and clears only on rst:
  - PCWrite != IF_ID_Write;
  - ControlSignalSelector == PCWrite (legal only as 1/0 or 0/1);
  - the consecutive-stall counter would exceed MAX_STALL.
- Violations do not alter datapath behaviour; each register follows its own input.
- Outputs are registered only; no combinational path from inputs to outputs.

Test Plan:
- Reset:
  - Stimulus: rst=1 for 2 cycles with random inputs.
  - Response: PC=0, both Valids=0, counters=0, ProtocolError=0. Then rst=0, PCWrite=1 → PC 0,4,8 on successive edges.
- Straight-line fetch:
  - Stimulus: no stall, Instr_in=0x8C08_0000 at PC=0.
  - Response: next edge IF_ID_Instr=0x8C08_0000, IF_ID_PCPlus4=4, Valid=1. Following edge ID_EX_Ctrl=Ctrl_in, ID_EX_Valid=1.
- Load-use stall:
  - Stimulus: triple (0,0,1) for one cycle at PC=8.
  - Response: PC stays 8, IF/ID unchanged, ID_EX_Ctrl=0, ID_EX_Valid=0, StallCount=1, no ProtocolError.
- Branch during stall:
  - Stimulus: BranchTaken=1, BranchTarget=0x40, triple (0,0,1).
  - Response: PC=0x40, IF_ID_Valid=0, ID_EX_Valid=0, FlushCount=1, StallCount unchanged.
- Protocol errors:
  - Stimulus: PCWrite=1, IF_ID_Write=0 for one cycle.
  - Response: ProtocolError=1 on the next edge and stays 1 until rst.
  - Separately: triple (0,0,1) for 3 cycles.
  - Response: ProtocolError=1 after the 3rd edge, StallCount=3.
- Wrap and saturation:
  - Stimulus: PC forced near top via branch to 0xFFFF_FFFC, then PCWrite=1.
  - Response: PC=0.
  - Stimulus: StallCount preloaded to all-ones by a long legal stall pattern, then another stall.
  - Response: StallCount stays 0xFFFF.
